// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters, registered blank/sync/strobe decode, frame counter.
// Optional VGA_SYNC_DELAY_EN delays hs/vs by SYNC_DELAY clocks to align with registered renderer RGB.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic       vga_clk,
  input  logic       reset,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       blank,
  output logic       hs,
  output logic       vs,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // 11-bit decode constants so a 1024-count raster still compares correctly
  localparam logic [9:0]  H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
    $fatal(1, "vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 1024");
  end
  if (SYNC_DELAY < 1 || SYNC_DELAY > 4) begin : g_bad_delay
    $fatal(1, "vga_timing_gen: SYNC_DELAY must be in 1..4");
  end

  logic [9:0] hc_reg, vc_reg;
  logic [9:0] hc_next, vc_next;
  logic       h_wrap, v_wrap;
  logic       visible_next, hs_active_next, vs_active_next;
  logic       blank_reg, hs_reg, vs_reg, line_start_reg, frame_start_reg;
  logic [7:0] frame_cnt_reg;

  always_comb begin
    h_wrap  = (hc_reg == H_LAST);
    v_wrap  = (vc_reg == V_LAST);
    hc_next = h_wrap ? 10'd0 : hc_reg + 10'd1;
    vc_next = vc_reg;
    if (h_wrap) begin
      vc_next = v_wrap ? 10'd0 : vc_reg + 10'd1;
    end
    visible_next   = ({1'b0, hc_next} < H_VIS_END) && ({1'b0, vc_next} < V_VIS_END);
    hs_active_next = ({1'b0, hc_next} >= H_SYNC_BEG) && ({1'b0, hc_next} < H_SYNC_END);
    vs_active_next = ({1'b0, vc_next} >= V_SYNC_BEG) && ({1'b0, vc_next} < V_SYNC_END);
  end

  // Decode from the next count so every output describes the pixel held in hc_reg/vc_reg
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      hc_reg          <= 10'd0;
      vc_reg          <= 10'd0;
      blank_reg       <= 1'b1;
      hs_reg          <= 1'b1;
      vs_reg          <= 1'b1;
      line_start_reg  <= 1'b1;
      frame_start_reg <= 1'b1;
      frame_cnt_reg   <= 8'd0;
    end else begin
      hc_reg          <= hc_next;
      vc_reg          <= vc_next;
      blank_reg       <= visible_next;
      hs_reg          <= ~hs_active_next;
      vs_reg          <= ~vs_active_next;
      line_start_reg  <= (hc_next == 10'd0);
      frame_start_reg <= (hc_next == 10'd0) && (vc_next == 10'd0);
      if (h_wrap && v_wrap) begin
        frame_cnt_reg <= frame_cnt_reg + 8'd1;
      end
    end
  end

  assign DrawX       = hc_reg;
  assign DrawY       = vc_reg;
  assign blank       = blank_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;
  assign frame_cnt   = frame_cnt_reg;

`ifdef VGA_SYNC_DELAY_EN
  genvar gi;
  // Stages reset high so no stale sync pulse survives a reset
  for (gi = 0; gi < SYNC_DELAY; gi++) begin : g_sync_pipe
    logic hs_stage_reg, vs_stage_reg;
    logic hs_src, vs_src;
    if (gi == 0) begin : g_first
      assign hs_src = hs_reg;
      assign vs_src = vs_reg;
    end else begin : g_rest
      assign hs_src = g_sync_pipe[gi-1].hs_stage_reg;
      assign vs_src = g_sync_pipe[gi-1].vs_stage_reg;
    end
    always_ff @(posedge vga_clk) begin
      if (reset) begin
        hs_stage_reg <= 1'b1;
        vs_stage_reg <= 1'b1;
      end else begin
        hs_stage_reg <= hs_src;
        vs_stage_reg <= vs_src;
      end
    end
  end
  assign hs = g_sync_pipe[SYNC_DELAY-1].hs_stage_reg;
  assign vs = g_sync_pipe[SYNC_DELAY-1].vs_stage_reg;
`else
  assign hs = hs_reg;
  assign vs = vs_reg;
`endif

endmodule
